// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Brief    : Shared constants, serializer state type and frame-length  |
// |            helper for the streaming UART transmitter.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } ser_state_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_stream_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_fifo                                                 |
// | Brief    : Single-clock show-ahead word FIFO with occupancy count.   |
// |            Head word is visible on rd_data while not empty.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_do_wr && !w_do_rd)      level_d = level_q + LVL_W'(1);
    else if (!w_do_wr && w_do_rd) level_d = level_q - LVL_W'(1);
  end

  // Control state, cleared asynchronously so the FIFO empties immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_stream_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_stream_tx                                            |
// | Brief    : Buffered multi-byte UART transmitter. Words enter through |
// |            valid/ready into a FIFO and leave as back-to-back frames. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_stream_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 2,
  parameter int PARITY       = 0,
  parameter int WORD_BYTES   = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WORD_BYTES*DATA_BITS-1:0]    in_data,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               overflow
);

  localparam int WORD_W = WORD_BYTES * DATA_BITS;
  localparam int TMR_W  = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [2:0]       FRAME_LAST = 3'(WORD_BYTES - 1);

  // Frame that goes out next: top slice when sending MSB-first, else bottom slice.
  function automatic logic [DATA_BITS-1:0] head_frame(input logic [WORD_W-1:0] w);
    if (MSB_FIRST != 0) return w[WORD_W-1 -: DATA_BITS];
    return w[DATA_BITS-1:0];
  endfunction

  // Remaining word after the head frame has been taken.
  function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
    if (MSB_FIRST != 0) return w << DATA_BITS;
    return w >> DATA_BITS;
  endfunction

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] f);
    if (PARITY == PARITY_ODD) return ~(^f);
    return ^f;
  endfunction

  logic [WORD_W-1:0]         w_fifo_rd_data;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_level;
  logic                      w_pop;
  logic                      w_load;
  logic [WORD_W-1:0]         w_load_src;
  logic                      w_wrap;

  ser_state_t                state_q,     state_d;
  logic [TMR_W-1:0]          timer_q,     timer_d;
  logic [3:0]                bit_cnt_q,   bit_cnt_d;
  logic [2:0]                frame_idx_q, frame_idx_d;
  logic [WORD_W-1:0]         word_q,      word_d;
  logic [DATA_BITS-1:0]      shift_q,     shift_d;
  logic                      parity_q,    parity_d;
  logic                      tx_q,        tx_d;

  // No bypass: a full FIFO refuses the word even if a pop happens this cycle.
  assign in_ready   = !w_fifo_full;
  assign overflow   = in_valid && w_fifo_full;
  assign fifo_level = w_fifo_level;
  assign busy       = (state_q != ST_IDLE) || (w_fifo_level != '0);
  assign tx         = tx_q;
  assign w_wrap     = (timer_q == TMR_LAST);
  assign w_load_src = (state_q == ST_IDLE) ? w_fifo_rd_data : word_q;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .level   (w_fifo_level)
  );

  // Serializer next-state: tx_d is the line level for the state being entered.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    frame_idx_d = frame_idx_q;
    word_d      = word_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    w_pop       = 1'b0;
    w_load      = 1'b0;

    if (state_q != ST_IDLE) timer_d = w_wrap ? '0 : timer_q + TMR_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          frame_idx_d = '0;
          timer_d     = '0;
          state_d     = ST_START;
          tx_d        = 1'b0;
        end
      end
      ST_START: if (w_wrap) begin
        bit_cnt_d = '0;
        state_d   = ST_DATA;
        tx_d      = shift_q[0];
      end
      ST_DATA: if (w_wrap) begin
        if (bit_cnt_q == DATA_LAST) begin
          bit_cnt_d = '0;
          if (PARITY != PARITY_NONE) begin
            state_d = ST_PARITY;
            tx_d    = parity_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          shift_d   = shift_q >> 1;
          tx_d      = shift_q[1];
        end
      end
      ST_PARITY: if (w_wrap) begin
        bit_cnt_d = '0;
        state_d   = ST_STOP;
        tx_d      = 1'b1;
      end
      ST_STOP: if (w_wrap) begin
        if (bit_cnt_q != STOP_LAST) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (frame_idx_q != FRAME_LAST) begin
          w_load      = 1'b1;
          frame_idx_d = frame_idx_q + 3'd1;
          state_d     = ST_START;
          tx_d        = 1'b0;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (w_load) begin
      shift_d  = head_frame(w_load_src);
      parity_d = frame_parity(head_frame(w_load_src));
      word_d   = next_word(w_load_src);
    end
  end

  // Serializer registers; reset abandons any frame in flight and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      frame_idx_q <= '0;
      word_q      <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_idx_q <= frame_idx_d;
      word_q      <= word_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
    end
  end

endmodule
`default_nettype wire
